// File: rtl/riscv_pkg.sv
// Shared RV32I front-end types and constants: IF/ID payload, opcodes, NOP encoding.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            pred_taken;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, pc: '0, instr: NOP_INSTR, pred_taken: 1'b0};

  // Instructions are word aligned; the two low byte-offset bits are dropped.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Combinational predecode of a fetched word for static prediction:
// flags JAL and backward conditional branches and extracts the sign-extended offset.
module fetch_predecode
  import riscv_pkg::*;
(
  input  logic [31:0]     instr_i,
  output logic            is_jal_o,
  output logic            is_bwd_branch_o,
  output logic [XLEN-1:0] imm_o
);

  logic [XLEN-1:0] j_imm;
  logic [XLEN-1:0] b_imm;

  assign j_imm = {{(XLEN-21){instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};
  assign b_imm = {{(XLEN-13){instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                  instr_i[11:8], 1'b0};

  // A set sign bit on a branch means a negative offset, i.e. a loop back-edge.
  assign is_jal_o        = (instr_i[6:0] == OPC_JAL);
  assign is_bwd_branch_o = (instr_i[6:0] == OPC_BRANCH) && instr_i[31];
  assign imm_o           = is_jal_o ? j_imm : b_imm;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: owns the PC, reads the combinational instruction memory and
// fills the IF/ID register. Static prediction is built only with FETCH_STATIC_PREDICT_EN.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned     IMEM_DEPTH = 128,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(0),
  localparam int unsigned    ADDR_W     = $clog2(IMEM_DEPTH * 4)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_rdata_i,
  output logic              if_id_valid_o,
  output logic [XLEN-1:0]   if_id_pc_o,
  output logic [31:0]       if_id_instr_o,
  output logic              if_id_pred_taken_o,
  output logic              misalign_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  if_id_t          if_id_q, if_id_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] next_pc;
  logic            pred_taken_c;

  assign seq_pc = pc_q + XLEN'(4);

`ifdef FETCH_STATIC_PREDICT_EN
  logic            pd_is_jal;
  logic            pd_is_bwd_branch;
  logic [XLEN-1:0] pd_imm;

  fetch_predecode u_predecode (
    .instr_i         (imem_rdata_i),
    .is_jal_o        (pd_is_jal),
    .is_bwd_branch_o (pd_is_bwd_branch),
    .imm_o           (pd_imm)
  );

  assign pred_taken_c = pd_is_jal | pd_is_bwd_branch;
  assign next_pc      = pred_taken_c ? (pc_q + pd_imm) : seq_pc;
`else
  assign pred_taken_c = 1'b0;
  assign next_pc      = seq_pc;
`endif

  // Redirect beats stall, stall beats normal fetch.
  always_comb begin
    pc_d       = pc_q;
    if_id_d    = if_id_q;
    misalign_d = 1'b0;
    if (redirect_i) begin
      pc_d       = align_word(redirect_pc_i);
      if_id_d    = IF_ID_BUBBLE;
      misalign_d = |redirect_pc_i[1:0];
    end else if (!stall_i) begin
      pc_d    = next_pc;
      if_id_d = '{valid: 1'b1, pc: pc_q, instr: imem_rdata_i, pred_taken: pred_taken_c};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      if_id_q    <= IF_ID_BUBBLE;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      if_id_q    <= if_id_d;
      misalign_q <= misalign_d;
    end
  end

  // Only the low address bits reach memory, so fetch wraps within the array.
  assign imem_addr_o        = pc_q[ADDR_W-1:0];
  assign if_id_valid_o      = if_id_q.valid;
  assign if_id_pc_o         = if_id_q.pc;
  assign if_id_instr_o      = if_id_q.instr;
  assign if_id_pred_taken_o = if_id_q.pred_taken;
  assign misalign_o         = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized stall/redirect
// traffic compared against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam int unsigned IMEM_DEPTH = 128;
  localparam int unsigned ADDR_W     = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall_i;
  logic              redirect_i;
  logic [31:0]       redirect_pc_i;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_rdata_i;
  logic              if_id_valid_o;
  logic [31:0]       if_id_pc_o;
  logic [31:0]       if_id_instr_o;
  logic              if_id_pred_taken_o;
  logic              misalign_o;

  logic [31:0] mem [IMEM_DEPTH];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_ipc;
  logic [31:0] m_instr;
  logic        m_pt;
  logic        m_mis;

  fetch_stage #(.IMEM_DEPTH(IMEM_DEPTH), .RESET_PC(32'h0)) dut (
    .clk                (clk),
    .rst                (rst),
    .stall_i            (stall_i),
    .redirect_i         (redirect_i),
    .redirect_pc_i      (redirect_pc_i),
    .imem_addr_o        (imem_addr_o),
    .imem_rdata_i       (imem_rdata_i),
    .if_id_valid_o      (if_id_valid_o),
    .if_id_pc_o         (if_id_pc_o),
    .if_id_instr_o      (if_id_instr_o),
    .if_id_pred_taken_o (if_id_pred_taken_o),
    .misalign_o         (misalign_o)
  );

  always #5 clk = ~clk;

  always_comb imem_rdata_i = mem[imem_addr_o[ADDR_W-1:2]];

  task automatic model_reset();
    m_pc = 32'h0; m_valid = 1'b0; m_ipc = 32'h0; m_instr = NOP_INSTR; m_pt = 1'b0; m_mis = 1'b0;
  endtask

`ifdef FETCH_STATIC_PREDICT_EN
  // Static prediction rule: JAL always, conditional branch when its offset is negative.
  task automatic model_predict(input logic [31:0] pc, input logic [31:0] w,
                               output logic [31:0] npc, output logic pt);
    logic signed [20:0] joff;
    logic signed [12:0] boff;
    joff = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    boff = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    npc = pc + 32'd4;
    pt  = 1'b0;
    if (w[6:0] == 7'b1101111) begin
      npc = pc + 32'(joff);
      pt  = 1'b1;
    end else if (w[6:0] == 7'b1100011 && boff < 0) begin
      npc = pc + 32'(boff);
      pt  = 1'b1;
    end
  endtask
`endif

  // Drive one cycle of inputs, advance the model, then sample 1 time unit past the edge.
  task automatic tick(input logic st, input logic rd, input logic [31:0] rpc);
    logic [31:0] w, npc;
    logic        pt;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    w = mem[m_pc[ADDR_W-1:2]];
    if (rd) begin
      m_pc = rpc & 32'hFFFF_FFFC;
      m_valid = 1'b0; m_ipc = 32'h0; m_instr = NOP_INSTR; m_pt = 1'b0;
      m_mis = (rpc % 4) != 0;
    end else begin
      m_mis = 1'b0;
      if (!st) begin
`ifdef FETCH_STATIC_PREDICT_EN
        model_predict(m_pc, w, npc, pt);
`else
        npc = m_pc + 32'd4;
        pt  = 1'b0;
`endif
        m_valid = 1'b1; m_ipc = m_pc; m_instr = w; m_pt = pt; m_pc = npc;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    model_reset();
    #12;
    checks++; if (imem_addr_o !== 9'h0)   begin errors++; $display("FAIL reset_addr got %h want 000", imem_addr_o); end
    checks++; if (if_id_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", if_id_valid_o); end
    checks++; if (if_id_pc_o !== 32'h0)   begin errors++; $display("FAIL reset_pc got %h want 0", if_id_pc_o); end
    checks++; if (if_id_instr_o !== NOP_INSTR) begin errors++; $display("FAIL reset_instr got %h want %h", if_id_instr_o, NOP_INSTR); end
    checks++; if (if_id_pred_taken_o !== 1'b0) begin errors++; $display("FAIL reset_pt got %b want 0", if_id_pred_taken_o); end
    checks++; if (misalign_o !== 1'b0)    begin errors++; $display("FAIL reset_mis got %b want 0", misalign_o); end
    rst = 1'b1;
    // A stalled first edge must not capture anything.
    tick(1'b1, 1'b0, 32'h0);
    checks++; if (if_id_valid_o !== 1'b0) begin errors++; $display("FAIL first_stall_valid got %b want 0", if_id_valid_o); end
    checks++; if (imem_addr_o !== 9'h0)   begin errors++; $display("FAIL first_stall_addr got %h want 000", imem_addr_o); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_w [3];
    exp_w[0] = mem[0]; exp_w[1] = mem[1]; exp_w[2] = mem[2];
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      checks++; if (imem_addr_o !== 9'((i + 1) * 4)) begin errors++; $display("FAIL seq_addr[%0d] got %h want %h", i, imem_addr_o, (i + 1) * 4); end
      checks++; if (if_id_valid_o !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %b want 1", i, if_id_valid_o); end
      checks++; if (if_id_pc_o !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc[%0d] got %h want %h", i, if_id_pc_o, i * 4); end
      checks++; if (if_id_instr_o !== exp_w[i]) begin errors++; $display("FAIL seq_instr[%0d] got %h want %h", i, if_id_instr_o, exp_w[i]); end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 32'h0);
      checks++; if (imem_addr_o !== 9'd12) begin errors++; $display("FAIL stall_addr[%0d] got %h want 00c", i, imem_addr_o); end
      checks++; if (if_id_pc_o !== 32'd8 || if_id_valid_o !== 1'b1 || if_id_instr_o !== mem[2])
        begin errors++; $display("FAIL stall_hold[%0d] got pc %h v %b i %h want pc 8 v 1 i %h", i, if_id_pc_o, if_id_valid_o, if_id_instr_o, mem[2]); end
    end
    tick(1'b0, 1'b0, 32'h0);
    checks++; if (if_id_pc_o !== 32'd12 || if_id_instr_o !== mem[3])
      begin errors++; $display("FAIL stall_resume got pc %h i %h want pc c i %h", if_id_pc_o, if_id_instr_o, mem[3]); end
    checks++; if (imem_addr_o !== 9'd16) begin errors++; $display("FAIL stall_resume_addr got %h want 010", imem_addr_o); end
  endtask

  task automatic test_redirect_stall();
    tick(1'b1, 1'b1, 32'h40);
    checks++; if (imem_addr_o !== 9'h40) begin errors++; $display("FAIL rds_addr got %h want 040", imem_addr_o); end
    checks++; if (if_id_valid_o !== 1'b0 || if_id_instr_o !== NOP_INSTR || if_id_pc_o !== 32'h0)
      begin errors++; $display("FAIL rds_bubble got v %b i %h pc %h want v 0 i 13 pc 0", if_id_valid_o, if_id_instr_o, if_id_pc_o); end
    tick(1'b0, 1'b0, 32'h0);
    checks++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h40 || if_id_instr_o !== mem[16])
      begin errors++; $display("FAIL rds_fetch got v %b pc %h i %h want v 1 pc 40 i %h", if_id_valid_o, if_id_pc_o, if_id_instr_o, mem[16]); end
    checks++; if (imem_addr_o !== m_pc[ADDR_W-1:0]) begin errors++; $display("FAIL rds_next_addr got %h want %h", imem_addr_o, m_pc[ADDR_W-1:0]); end
  endtask

  task automatic test_misalign();
    tick(1'b0, 1'b1, 32'h42);
    checks++; if (imem_addr_o !== 9'h40) begin errors++; $display("FAIL mis_addr got %h want 040", imem_addr_o); end
    checks++; if (misalign_o !== 1'b1)   begin errors++; $display("FAIL mis_pulse got %b want 1", misalign_o); end
    tick(1'b0, 1'b0, 32'h0);
    checks++; if (misalign_o !== 1'b0)   begin errors++; $display("FAIL mis_clear got %b want 0", misalign_o); end
    tick(1'b0, 1'b1, 32'h80);
    checks++; if (misalign_o !== 1'b0)   begin errors++; $display("FAIL mis_aligned got %b want 0", misalign_o); end
  endtask

  task automatic test_wrap();
    mem[127] = NOP_INSTR;
    mem[0]   = 32'h0010_0093;
    tick(1'b0, 1'b1, 32'h1FC);
    checks++; if (imem_addr_o !== 9'h1FC) begin errors++; $display("FAIL wrap_start got %h want 1fc", imem_addr_o); end
    tick(1'b0, 1'b0, 32'h0);
    checks++; if (imem_addr_o !== 9'h000) begin errors++; $display("FAIL wrap_addr got %h want 000", imem_addr_o); end
    tick(1'b0, 1'b0, 32'h0);
    checks++; if (if_id_pc_o !== 32'h200 || if_id_instr_o !== 32'h0010_0093)
      begin errors++; $display("FAIL wrap_pc got pc %h i %h want pc 200 i 00100093", if_id_pc_o, if_id_instr_o); end
    // Full XLEN wrap from the top of the address space.
    tick(1'b0, 1'b1, 32'hFFFF_FFFF);
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    checks++; if (if_id_pc_o !== 32'h0) begin errors++; $display("FAIL xlen_wrap got %h want 0", if_id_pc_o); end
  endtask

`ifdef FETCH_STATIC_PREDICT_EN
  task automatic test_predict();
    mem[8] = 32'hFE00_0CE3;  // beq x0,x0,-8
    mem[6] = 32'h0000_0463;  // beq x0,x0,+8
    tick(1'b0, 1'b1, 32'h20);
    tick(1'b0, 1'b0, 32'h0);
    checks++; if (imem_addr_o !== 9'h18 || if_id_pred_taken_o !== 1'b1 || if_id_pc_o !== 32'h20)
      begin errors++; $display("FAIL pred_bwd got addr %h pt %b pc %h want addr 018 pt 1 pc 20", imem_addr_o, if_id_pred_taken_o, if_id_pc_o); end
    tick(1'b0, 1'b0, 32'h0);
    checks++; if (imem_addr_o !== 9'h1C || if_id_pred_taken_o !== 1'b0 || if_id_pc_o !== 32'h18)
      begin errors++; $display("FAIL pred_fwd got addr %h pt %b pc %h want addr 01c pt 0 pc 18", imem_addr_o, if_id_pred_taken_o, if_id_pc_o); end
  endtask
`endif

  task automatic test_random();
    logic st, rd;
    logic [31:0] rpc;
    for (int i = 0; i < IMEM_DEPTH; i++) mem[i] = $urandom;
    for (int n = 0; n < 400; n++) begin
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      tick(st, rd, rpc);
      checks++; if (imem_addr_o !== m_pc[ADDR_W-1:0]) begin errors++; $display("FAIL rnd_addr[%0d] got %h want %h", n, imem_addr_o, m_pc[ADDR_W-1:0]); end
      checks++; if (if_id_valid_o !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", n, if_id_valid_o, m_valid); end
      checks++; if (if_id_pc_o !== m_ipc) begin errors++; $display("FAIL rnd_pc[%0d] got %h want %h", n, if_id_pc_o, m_ipc); end
      checks++; if (if_id_instr_o !== m_instr) begin errors++; $display("FAIL rnd_instr[%0d] got %h want %h", n, if_id_instr_o, m_instr); end
      checks++; if (if_id_pred_taken_o !== m_pt) begin errors++; $display("FAIL rnd_pt[%0d] got %b want %b", n, if_id_pred_taken_o, m_pt); end
      checks++; if (misalign_o !== m_mis) begin errors++; $display("FAIL rnd_mis[%0d] got %b want %b", n, misalign_o, m_mis); end
    end
  endtask

  task automatic test_midreset();
    tick(1'b0, 1'b1, 32'h0000_0102);
    tick(1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    #2;
    model_reset();
    checks++; if (imem_addr_o !== 9'h0 || if_id_valid_o !== 1'b0 || if_id_pc_o !== 32'h0 ||
                  if_id_instr_o !== NOP_INSTR || if_id_pred_taken_o !== 1'b0 || misalign_o !== 1'b0)
      begin errors++; $display("FAIL midreset got addr %h v %b pc %h i %h pt %b mis %b want all reset", imem_addr_o, if_id_valid_o, if_id_pc_o, if_id_instr_o, if_id_pred_taken_o, misalign_o); end
    rst = 1'b1;
    #1;
    for (int n = 0; n < 2; n++) begin
      tick(1'b0, 1'b0, 32'h0);
      checks++; if (if_id_pc_o !== m_ipc || if_id_instr_o !== m_instr || imem_addr_o !== m_pc[ADDR_W-1:0])
        begin errors++; $display("FAIL post_reset[%0d] got pc %h i %h a %h want pc %h i %h a %h", n, if_id_pc_o, if_id_instr_o, imem_addr_o, m_ipc, m_instr, m_pc[ADDR_W-1:0]); end
    end
  endtask

  initial begin
    for (int i = 0; i < IMEM_DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'h0010_0093;
    mem[1] = 32'h0020_0113;
    mem[2] = 32'h0030_8193;
    mem[3] = 32'h0041_8213;
    mem[16] = NOP_INSTR;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_stall();
    test_misalign();
    test_wrap();
`ifdef FETCH_STATIC_PREDICT_EN
    test_predict();
`endif
    test_random();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
